// File: rtl/pc_unit.sv
// pc_unit: program counter and fetch-enable generator for the CPU front end.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous active-high reset (state OFF, all outputs 0)
//   stall_i        hold pc_o with fetch still enabled
//   redirect_i     take redirect_pc_i on the next edge
//   redirect_pc_i  branch/jump target
//   trap_i         take TRAP_VEC on the next edge (highest priority)
//   halt_i         enter HALT (fetch disabled, pc_o held)
//   resume_i       leave HALT and restart fetch at the held address
//   ce_o           instruction-memory read enable (high in RUN)
//   pc_o           current fetch address
//   halted_o       high while in HALT
//   misalign_o     one-cycle pulse on a misaligned redirect
//   badaddr_o      last misaligned redirect target
//
// Optional feature macro: PC_MISALIGN_CHECK_EN.
//   Defined:   a misaligned redirect in RUN traps to TRAP_VEC instead of being
//              taken, pulses misalign_o and records the target in badaddr_o.
//   Undefined: the low log2(INST_BYTES) target bits are cleared, and
//              misalign_o / badaddr_o are tied to 0.
module pc_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [31:0]       TRAP_VEC   = 32'h0000_0020,
    parameter int unsigned       INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              trap_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic              ce_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] badaddr_o
);
    localparam logic [ADDR_W-1:0] TRAP = ADDR_W'(TRAP_VEC);
    localparam logic [ADDR_W-1:0] INC  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW  = ADDR_W'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              bad_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            pc    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // bad_tgt is constant 0 without the check, so redirects are always taken
    // with their low bits cleared.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        case (state)
            S_OFF: begin
                state_n = S_RUN;
                pc_n    = RESET_VEC;
            end
            S_RUN: begin
                if (trap_i)
                    pc_n = TRAP;
                else if (redirect_i)
                    pc_n = bad_tgt ? TRAP : (redirect_pc_i & ~LOW);
                else if (halt_i)
                    state_n = S_HALT;
                else if (!stall_i)
                    pc_n = pc + INC;
            end
            S_HALT: begin
                if (trap_i) begin
                    state_n = S_RUN;
                    pc_n    = TRAP;
                end else if (resume_i) begin
                    state_n = S_RUN;
                end
            end
            default: begin
                state_n = S_OFF;
                pc_n    = '0;
            end
        endcase
    end

    assign ce_o     = (state == S_RUN);
    assign halted_o = (state == S_HALT);
    assign pc_o     = pc;

`ifdef PC_MISALIGN_CHECK_EN
    logic              misalign, misalign_n;
    logic [ADDR_W-1:0] badaddr;

    assign bad_tgt    = |(redirect_pc_i & LOW);
    // An explicit trap in the same cycle suppresses the misalign report.
    assign misalign_n = (state == S_RUN) && !trap_i && redirect_i && bad_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
            badaddr  <= '0;
        end else begin
            misalign <= misalign_n;
            if (misalign_n)
                badaddr <= redirect_pc_i;
        end
    end

    assign misalign_o = misalign;
    assign badaddr_o  = badaddr;
`else
    assign bad_tgt    = 1'b0;
    assign misalign_o = 1'b0;
    assign badaddr_o  = '0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (32-bit and 8-bit instances on shared stimulus).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, red, trap, halt, resume;
    logic [31:0] rpc;

    logic        ce0, hl0, mis0, ce1, hl1, mis1;
    logic [31:0] pc0, bad0;
    logic [7:0]  pc1, bad1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_unit d0 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(red), .redirect_pc_i(rpc),
        .trap_i(trap), .halt_i(halt), .resume_i(resume), .ce_o(ce0), .pc_o(pc0),
        .halted_o(hl0), .misalign_o(mis0), .badaddr_o(bad0)
    );

    pc_unit #(.ADDR_W(8)) d1 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(red), .redirect_pc_i(rpc[7:0]),
        .trap_i(trap), .halt_i(halt), .resume_i(resume), .ce_o(ce1), .pc_o(pc1),
        .halted_o(hl1), .misalign_o(mis1), .badaddr_o(bad1)
    );

    typedef struct {
        logic            ce;
        logic            halted;
        logic            mis;
        longint unsigned pc;
        longint unsigned bad;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: 0=OFF 1=RUN 2=HALT, addresses kept as plain integers.
    int              m_st [2] = '{0, 0};
    longint unsigned m_pc [2] = '{0, 0};
    longint unsigned m_bad[2] = '{0, 0};
    logic            m_mis[2] = '{1'b0, 1'b0};
    longint unsigned span [2] = '{64'h1_0000_0000, 64'h100};

    task automatic model(input int i);
        longint unsigned t;
        exp_t e;
        t = longint'(rpc) % span[i];
        m_mis[i] = 1'b0;
        if (rst) begin
            m_st[i] = 0; m_pc[i] = 0; m_bad[i] = 0;
        end else if (m_st[i] == 0) begin
            m_st[i] = 1; m_pc[i] = 0;
        end else if (m_st[i] == 1) begin
            if (trap) m_pc[i] = 32 % span[i];
            else if (red) begin
`ifdef PC_MISALIGN_CHECK_EN
                if (t % 4 != 0) begin
                    m_pc[i] = 32; m_mis[i] = 1'b1; m_bad[i] = t;
                end else m_pc[i] = t;
`else
                m_pc[i] = t - t % 4;
`endif
            end
            else if (halt) m_st[i] = 2;
            else if (!stall) m_pc[i] = (m_pc[i] + 4) % span[i];
        end else begin
            if (trap) begin m_st[i] = 1; m_pc[i] = 32; end
            else if (resume) m_st[i] = 1;
        end
        e.ce = (m_st[i] == 1); e.halted = (m_st[i] == 2); e.mis = m_mis[i];
        e.pc = m_pc[i]; e.bad = m_bad[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic cyc(input logic r, s, rd, input logic [31:0] rp, input logic tp, h, rs);
        @(negedge clk);
        rst = r; stall = s; red = rd; rpc = rp; trap = tp; halt = h; resume = rs;
        model(0);
        model(1);
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0_ce", 64'(ce0), 64'(e.ce));
            chk("d0_halted", 64'(hl0), 64'(e.halted));
            chk("d0_pc", 64'(pc0), e.pc);
            chk("d0_misalign", 64'(mis0), 64'(e.mis));
            chk("d0_badaddr", 64'(bad0), e.bad);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1_ce", 64'(ce1), 64'(e.ce));
            chk("d1_halted", 64'(hl1), 64'(e.halted));
            chk("d1_pc", 64'(pc1), e.pc);
            chk("d1_misalign", 64'(mis1), 64'(e.mis));
            chk("d1_badaddr", 64'(bad1), e.bad);
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; red = 1'b0; rpc = '0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h40, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        repeat (5) cyc(0, 0, 1, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h102, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h203, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            cyc($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, t,
                $urandom_range(19) == 0, $urandom_range(15) == 0, $urandom_range(3) == 0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter and fetch-enable generator at the front of the pipelined CPU; drives instruction-ROM address and chip enable.
- Successor to the fixed +4 PC.
- Adds configurable width, reset and trap vectors, stall hold, branch/jump redirect, trap redirect, and a halt/resume state machine.

Parameters:
- ADDR_W, 32, width of pc_o and all address inputs.
- RESET_VEC, 0, first fetch address after reset.
- TRAP_VEC, 32'h0000_0020, fetch address taken on trap_i (truncated to ADDR_W).
- INST_BYTES, 4, PC increment; power of two, 1..8.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  hold pc_o (pipeline hazard).
- redirect_i  in  1  take redirect_pc_i next cycle (branch/jump resolved).
- redirect_pc_i  in  ADDR_W  redirect target.
- trap_i  in  1  take TRAP_VEC next cycle.
- halt_i  in  1  request halt.
- resume_i  in  1  leave halt.
- ce_o  out  1  instruction-memory read enable.
- pc_o  out  ADDR_W  current fetch address.
- halted_o  out  1  high while in HALT.
- misalign_o  out  1  misaligned-redirect pulse (feature only; tied 0 otherwise).
- badaddr_o  out  ADDR_W  last misaligned target (feature only; tied 0 otherwise).

Behaviour:
- Reset: while rst=1 at an edge, state=OFF and all outputs are 0 (ce_o=0, pc_o=0, halted_o=0, misalign_o=0, badaddr_o=0).
- OFF: first edge with rst=0 -> RUN, ce_o=1, pc_o=RESET_VEC. ce_o therefore rises exactly 1 cycle after rst falls.
- RUN: next-PC priority per edge, highest first:
  - trap_i -> TRAP_VEC.
  - redirect_i -> redirect_pc_i.
  - halt_i -> HALT; pc_o held, ce_o=0, halted_o=1.
  - stall_i -> pc_o held, ce_o stays 1.
  - otherwise pc_o + INST_BYTES, modulo 2^ADDR_W (wraps from max to 0 silently).
- Trap or redirect in the same cycle as stall_i or halt_i: the trap/redirect wins, stall/halt is ignored that cycle, state stays RUN.
- HALT:
  - ce_o=0, pc_o held, halted_o=1.
  - trap_i -> RUN, pc_o=TRAP_VEC, ce_o=1.
  - else resume_i -> RUN, ce_o=1, pc_o unchanged; fetch restarts at the held address.
  - redirect_i and stall_i are ignored in HALT.
- Without the feature, the low log2(INST_BYTES) bits of redirect_pc_i are forced to 0.
- rst=1 from any state, mid-stall or mid-halt: returns to OFF the next edge.
- Latency: every control input takes effect on pc_o at the next edge; there is no combinational path from input to output.
- States: OFF, RUN, HALT; 2-bit encoding; the illegal encoding goes to OFF.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - A redirect in RUN whose target has nonzero low log2(INST_BYTES) bits is not taken.
  - Instead pc_o=TRAP_VEC, misalign_o=1 for exactly 1 cycle, badaddr_o=target (held until the next misalign or reset).
  - An explicit trap_i in the same cycle still wins, and no misalign pulse is generated.
- Undefined: target low bits are masked as described in Behaviour; misalign_o and badaddr_o are tied 0.

Test Plan:
- Reset release: rst=1 for 3 cycles then 0 -> ce_o=0 during reset; next edge ce_o=1, pc_o=0; then pc_o 4, 8, 12 on successive edges.
- Stall and redirect: at pc_o=8 assert stall_i for 2 cycles -> pc_o stays 8; then redirect_i=1 with redirect_pc_i=0x100 and stall_i=1 together -> pc_o=0x100, then 0x104.
- Trap priority: trap_i=1 and redirect_i=1 (0x40) in the same cycle -> pc_o=0x20, then 0x24.
- Halt: halt_i at pc_o=0x10 -> halted_o=1, ce_o=0, pc_o=0x10 held for 5 cycles despite redirect_i; resume_i -> ce_o=1, pc_o=0x10, then 0x14.
- Wrap and mid-op reset: ADDR_W=8, pc_o=0xFC -> next pc_o=0x00; assert rst while halted -> OFF, all outputs 0.
- Misalign (macro defined): redirect to 0x102 -> pc_o=0x20, misalign_o=1 for one cycle, badaddr_o=0x102. Macro undefined: the same redirect gives pc_o=0x100.
